// File: rtl/fpmul_result_buffer.sv
// Result buffer behind the fpmul multiplier: it classifies each product, queues it in a FIFO and keeps saturating per-class counters.
// Defining FPMUL_BUF_FTZ_EN stores each denormal as a signed zero with class zero.
module fpmul_result_buffer #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [31:0]                in_result,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [31:0]                out_data,
   output logic [2:0]                 out_class,
   output logic [$clog2(DEPTH):0]     occupancy,
   input  logic                       cnt_clr,
   output logic [CNT_W-1:0]           cnt_zero,
   output logic [CNT_W-1:0]           cnt_denorm,
   output logic [CNT_W-1:0]           cnt_inf,
   output logic [CNT_W-1:0]           cnt_nan
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   localparam logic [2:0] CLS_NORMAL = 3'd0;
   localparam logic [2:0] CLS_ZERO   = 3'd1;
   localparam logic [2:0] CLS_DENORM = 3'd2;
   localparam logic [2:0] CLS_INF    = 3'd3;
   localparam logic [2:0] CLS_NAN    = 3'd4;

   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [31:0]   mem_data  [DEPTH];
   logic [2:0]    mem_class [DEPTH];

   logic          full, empty, push, pop;
   logic [2:0]    raw_class;
   logic [2:0]    store_class;
   logic [31:0]   store_data;

   assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty     = (wr_ptr == rd_ptr);
   assign in_ready  = !full && !reset;
   assign out_valid = !empty;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign occupancy = wr_ptr - rd_ptr;
   assign out_data  = empty ? 32'd0 : mem_data[rd_ptr[AW-1:0]];
   assign out_class = empty ? 3'd0  : mem_class[rd_ptr[AW-1:0]];

   // Classify by exponent/fraction only; the sign bit never matters.
   always_comb begin
      raw_class = CLS_NORMAL;
      if (in_result[30:23] == 8'hFF)
         raw_class = (in_result[22:0] != 23'd0) ? CLS_NAN : CLS_INF;
      else if (in_result[30:23] == 8'h00)
         raw_class = (in_result[22:0] != 23'd0) ? CLS_DENORM : CLS_ZERO;
   end

   always_comb begin
      store_data  = in_result;
      store_class = raw_class;
`ifdef FPMUL_BUF_FTZ_EN
      if (raw_class == CLS_DENORM) begin
         store_data  = {in_result[31], 31'd0};
         store_class = CLS_ZERO;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end
   end

   // Storage needs no reset; the read side is gated to zero while empty.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_data[wr_ptr[AW-1:0]]  <= store_data;
         mem_class[wr_ptr[AW-1:0]] <= store_class;
      end
   end

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // Counters track the raw class, so denormals count even when flushed.
   always_ff @(posedge clk) begin
      if (reset || cnt_clr) begin
         cnt_zero   <= '0;
         cnt_denorm <= '0;
         cnt_inf    <= '0;
         cnt_nan    <= '0;
      end else if (push) begin
         case (raw_class)
            CLS_ZERO:   cnt_zero   <= sat_inc(cnt_zero);
            CLS_DENORM: cnt_denorm <= sat_inc(cnt_denorm);
            CLS_INF:    cnt_inf    <= sat_inc(cnt_inf);
            CLS_NAN:    cnt_nan    <= sat_inc(cnt_nan);
            default:    ;
         endcase
      end
   end

endmodule

// File: doc/fpmul_result_buffer.md
Name: fpmul_result_buffer

Overview:
- Downstream stage of the combinational single-precision multiplier (fpmul).
- Accepts each 32-bit IEEE-754 product over a valid/ready handshake and classifies it as normal, zero, denormal, infinity or NaN.
- Buffers product and class in a small FIFO for the consumer (result logger or accumulator).
- Keeps saturating per-class event counters for test and debug visibility.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- CNT_W, 16, width of each class counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  product on in_result is valid this cycle.
- in_ready  output  1  buffer can accept; equals !full && !reset.
- in_result  input  32  product from fpmul {sign, exp[7:0], frac[22:0]}.
- out_valid  output  1  FIFO head is valid.
- out_ready  input  1  consumer takes the head this cycle.
- out_data  output  32  head product.
- out_class  output  3  head class: 0 normal, 1 zero, 2 denormal, 3 inf, 4 NaN.
- occupancy  output  log2(DEPTH)+1  number of stored entries.
- cnt_clr  input  1  synchronous clear of all class counters.
- cnt_zero, cnt_denorm, cnt_inf, cnt_nan  output  CNT_W each  accepted-product counts per class.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: all pointers 0, occupancy 0, out_valid 0, out_data 0, out_class 0, all counters 0. in_ready is 0 while reset is high and 1 in the first cycle after release.
- Reset mid-operation: all stored entries are discarded, and any push or pop in that cycle is ignored.
- Push: occurs when in_valid && in_ready. The entry is written at the write pointer. out_valid rises on the next edge if the FIFO was empty, so push-to-head latency is 1 cycle with no combinational path from in to out.
- Pop: occurs when out_valid && out_ready. The read pointer advances.
- out_data and out_class are 0 whenever the FIFO is empty.
- Pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH. full means MSBs differ and the rest are equal; empty means the pointers are equal. occupancy = wr_ptr - rd_ptr.
- Simultaneous push and pop, not full and not empty: both occur and occupancy is unchanged.
- Simultaneous push and pop when empty: only the push occurs, since out_valid is 0.
- When full: in_ready is 0, even if out_ready is 1 that cycle, so there is no pass-through. An in_valid asserted while in_ready is 0 has no effect; the producer must hold it.
- Classification is combinational on in_result, with e = exp and f = frac:
  - e = 8'hFF, f != 0 -> NaN (4)
  - e = 8'hFF, f == 0 -> inf (3)
  - e = 0, f == 0 -> zero (1)
  - e = 0, f != 0 -> denormal (2)
  - otherwise -> normal (0)
  - The sign bit is ignored for classification.
- Counters: on each push, the counter for that class increments by 1 and saturates at 2^CNT_W-1. Normals are not counted.
- cnt_clr: clears all counters and has priority over an increment in the same cycle, so that push is not counted. cnt_clr does not affect the FIFO.

Optional Feature:
- Macro FPMUL_BUF_FTZ_EN.
- When defined (flush-to-zero), a denormal input is stored as {sign, 31'b0} with class 1 (zero). cnt_denorm still increments, because it records occurrences; cnt_zero does not.
- When undefined, denormals are stored unchanged with class 2.

Test Plan:
- Reset, then push 32'h3F800000 (1.0) with out_ready=0 -> next cycle out_valid=1, out_data=32'h3F800000, out_class=0, occupancy=1, all counters 0.
- Push 32'h7F800000, 32'hFFC00000, 32'h80000000, 32'h00000001 back-to-back with out_ready=0 -> in_ready drops after the 4th push (DEPTH=4); cnt_inf=1, cnt_nan=1, cnt_zero=1, cnt_denorm=1; heads pop in order with classes 3, 4, 1, 2. With FPMUL_BUF_FTZ_EN, the 4th head is 32'h00000000 with class 1 and cnt_denorm=1.
- Full FIFO, in_valid=1, out_ready=1 for one cycle -> only the pop occurs and occupancy goes 4 -> 3. Next cycle with both still high -> push and pop together, occupancy stays 3.
- Stream 10 pushes with out_ready=1 throughout -> pointers wrap, output order matches input order, no entry lost or duplicated.
- Run with CNT_W=2 and push 5 infinities -> cnt_inf saturates at 3. Then assert cnt_clr together with a push of 32'h7F800000 -> cnt_inf=0 the next cycle.
- Assert reset for one cycle with occupancy=3 and in_valid=1 -> next cycle occupancy=0, out_valid=0, out_data=0, counters 0, in_ready=1.
